axil_ctrl_regs: RTL and testbench
=================================

// Module: axil_ctrl_regs
// PURPOSE
//  AXI4-Lite responder (slave) register bank for a kernel's s_axi_control port.
//  Terminates host AW/W/B and AR/R traffic, holds three RW user registers and an ap_ctrl word, and exports them to the datapath.
//  Sits between the host interconnect and the kernel core. Serves the same control map that host-side bus masters program.
// PARAMETERS
//  C_S_AXI_CONTROL_ADDR_WIDTH  12  byte-address width; offsets decoded on [ADDR_WIDTH-1:2]
//  C_S_AXI_CONTROL_DATA_WIDTH  32  data width; only 32 supported
// PORTS
//  ap_clk                 in   1    single clock; all logic rising-edge
//  ap_rst                 in   1    synchronous reset, active-high
//  s_axi_control_awvalid  in   1    write address valid
//  s_axi_control_awready  out  1    write address ready
//  s_axi_control_awaddr   in   AW   write byte address
//  s_axi_control_wvalid   in   1    write data valid
//  s_axi_control_wready   out  1    write data ready
//  s_axi_control_wdata    in   32   write data
//  s_axi_control_wstrb    in   4    byte enables
//  s_axi_control_bvalid   out  1    write response valid
//  s_axi_control_bready   in   1    write response ready
//  s_axi_control_bresp    out  2    write response
//  s_axi_control_arvalid  in   1    read address valid
//  s_axi_control_arready  out  1    read address ready
//  s_axi_control_araddr   in   AW   read byte address
//  s_axi_control_rvalid   out  1    read data valid
//  s_axi_control_rready   in   1    read data ready
//  s_axi_control_rdata    out  32   read data
//  s_axi_control_rresp    out  2    read response
//  ap_start               out  1    kernel start level
//  ap_done_i              in   1    kernel done pulse, 1 cycle
//  ap_idle_i              in   1    kernel idle level
//  user_reg0/1/2          out  32   RW registers at 0x10/0x18/0x20
//  status_i               in   32   RO status, visible at 0x28
// BEHAVIOUR
//  Reset (ap_rst=1 at edge): all outputs 0, including awready/arready. FSMs go to IDLE; user_regs=0; done_sticky=0.
//  Write FSM: WR_IDLE(awready=1) -AW hs-> WR_DATA(wready=1) -W hs-> WR_RESP(bvalid=1) -B hs-> WR_IDLE.
//  The address is latched at AW hs. Register update happens at the W hs edge, per-byte under wstrb. wstrb=0 gives no change and bresp=OKAY.
//  Encoding 2'd3 (WR_RST) is unreachable and recovers to WR_IDLE. AW and W arriving in the same cycle: AW is taken first, W is taken the next cycle.
//  Read FSM: RD_IDLE(arready=1) -AR hs-> RD_DATA(rvalid=1, rdata/rresp held stable) -R hs-> RD_IDLE.
//  rdata is sampled from register contents at the AR hs edge. Latency from AR hs to rvalid is 1 cycle.
//  Read and write to the same register in the same edge: the read returns the pre-write value.
//  Map: 0x00 CTRL {bit2 ap_idle_i, bit1 done_sticky, bit0 ap_start}. 0x10/0x18/0x20 user_reg0..2 RW. 0x28 status_i RO.
//  CTRL write with wdata[0]=1 and wstrb[0]=1 sets ap_start. ap_start holds until the ap_done_i edge, then clears.
//  done_sticky is set by ap_done_i and cleared by an AR hs to 0x00. When set and clear occur on the same edge, set wins.
//  Writes to RO or CTRL bits other than bit0 are ignored. Address bits [1:0] are ignored.
//  Reset mid-transaction aborts it: no response is issued and no register is updated.
// CONFIGURATION
//  AXIL_CTRL_REGS_SLVERR_EN defined: unmapped offsets return bresp/rresp=2'b10 (SLVERR) with rdata=0, and writes are dropped.
//  Not defined: unmapped offsets return OKAY and rdata=0, and writes are dropped. Valid offsets always return OKAY.
// STRUCTURE
//  axil_ctrl_pkg holds: offset localparams (CTRL=0x00, REG0=0x10, REG1=0x18, REG2=0x20, STATUS=0x28); RESP_OKAY=2'b00, RESP_SLVERR=2'b10; WR_IDLE..WR_RST = 2'd0..3; RD_IDLE=1'b0, RD_DATA=1'b1.
//  One sub-module, axil_ctrl_bytereg: a 32-bit register with per-byte wstrb write enable and sync reset. It is instantiated three times.
// TESTING
//  1. Write 0x1111_1111@0x10, 0x2222_2222@0x18, 0x3333_3333@0x20, then read each back. Each read returns the matching value with rresp=0, and user_regN equals it.
//  2. Write 0xAABB_CCDD@0x10 with wstrb=4'b0101 after 0x1111_1111. The readback is 0x11BB_11DD.
//  3. Write 1@0x00, pulse ap_done_i. ap_start goes 1 then 0 after the pulse. Reading 0x00 returns bit1=1; a second read returns bit1=0.
//  4. Read 0x3C: rdata=0. rresp=2'b10 with AXIL_CTRL_REGS_SLVERR_EN, else 0. A write to 0x3C returns the same bresp, and no register changes.
//  5. Hold bready/rready low for 5 cycles. bvalid/rvalid stay high with stable rdata/bresp, and no new AW/AR is accepted.
//  6. Assert ap_rst while in WR_DATA. All outputs are 0 on the next edge, no bvalid follows, and awready=1 after release.

Source files
------------

// File: rtl/axil_ctrl_pkg.sv
// axil_ctrl_pkg: control map offsets, response codes and FSM state encodings
package axil_ctrl_pkg;
    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_REG0   = 12'h010;
    localparam logic [11:0] OFF_REG1   = 12'h018;
    localparam logic [11:0] OFF_REG2   = 12'h020;
    localparam logic [11:0] OFF_STATUS = 12'h028;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        WR_RST  = 2'd3
    } wr_state_t;
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;
endpackage

// File: rtl/axil_ctrl_bytereg.sv
// axil_ctrl_bytereg: 32-bit register with per-byte write enables and sync reset
module axil_ctrl_bytereg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  wstrb,
    input  logic [31:0] d,
    output logic [31:0] q
);
    // update only the bytes selected by wstrb
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (we)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) q[8*i +: 8] <= d[8*i +: 8];
    end
endmodule

// File: rtl/axil_ctrl_regs.sv
// axil_ctrl_regs: AXI4-Lite control register bank (CTRL, three RW user regs, RO status)
// Optional: define AXIL_CTRL_REGS_SLVERR_EN to answer unmapped offsets with SLVERR.
module axil_ctrl_regs
    import axil_ctrl_pkg::*;
#(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst,
    input  logic                                    s_axi_control_awvalid,
    output logic                                    s_axi_control_awready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                                    s_axi_control_wvalid,
    output logic                                    s_axi_control_wready,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                                    s_axi_control_bvalid,
    input  logic                                    s_axi_control_bready,
    output logic [1:0]                              s_axi_control_bresp,
    input  logic                                    s_axi_control_arvalid,
    output logic                                    s_axi_control_arready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                                    s_axi_control_rvalid,
    input  logic                                    s_axi_control_rready,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                              s_axi_control_rresp,
    output logic                                    ap_start,
    input  logic                                    ap_done_i,
    input  logic                                    ap_idle_i,
    output logic [31:0]                             user_reg0,
    output logic [31:0]                             user_reg1,
    output logic [31:0]                             user_reg2,
    input  logic [31:0]                             status_i
);
    localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);
`ifdef AXIL_CTRL_REGS_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_UNMAPPED = RESP_OKAY;
`endif

    wr_state_t     wr_state;
    rd_state_t     rd_state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_off;
    logic [AW-1:0] rd_off;
    logic          done_sticky;
    logic          wr_hs;
    logic          ar_hs;
    logic          wr_hit;
    logic          rd_hit;
    logic [31:0]   rd_val;

    // byte-lane offsets with the sub-word address bits dropped
    always_comb begin
        wr_off = wr_addr & WORD_MASK;
        rd_off = s_axi_control_araddr & WORD_MASK;
        wr_hs  = s_axi_control_wready & s_axi_control_wvalid;
        ar_hs  = s_axi_control_arready & s_axi_control_arvalid;
        wr_hit = wr_off == AW'(OFF_CTRL) || wr_off == AW'(OFF_REG0) || wr_off == AW'(OFF_REG1)
              || wr_off == AW'(OFF_REG2) || wr_off == AW'(OFF_STATUS);
        rd_hit = rd_off == AW'(OFF_CTRL) || rd_off == AW'(OFF_REG0) || rd_off == AW'(OFF_REG1)
              || rd_off == AW'(OFF_REG2) || rd_off == AW'(OFF_STATUS);
        rd_val = rd_off == AW'(OFF_CTRL)   ? {29'd0, ap_idle_i, done_sticky, ap_start} :
                 rd_off == AW'(OFF_REG0)   ? user_reg0 :
                 rd_off == AW'(OFF_REG1)   ? user_reg1 :
                 rd_off == AW'(OFF_REG2)   ? user_reg2 :
                 rd_off == AW'(OFF_STATUS) ? status_i  : 32'd0;
    end

    axil_ctrl_bytereg u_reg0 (
        .clk(ap_clk), .rst(ap_rst), .we(wr_hs && wr_off == AW'(OFF_REG0)),
        .wstrb(s_axi_control_wstrb), .d(s_axi_control_wdata), .q(user_reg0)
    );
    axil_ctrl_bytereg u_reg1 (
        .clk(ap_clk), .rst(ap_rst), .we(wr_hs && wr_off == AW'(OFF_REG1)),
        .wstrb(s_axi_control_wstrb), .d(s_axi_control_wdata), .q(user_reg1)
    );
    axil_ctrl_bytereg u_reg2 (
        .clk(ap_clk), .rst(ap_rst), .we(wr_hs && wr_off == AW'(OFF_REG2)),
        .wstrb(s_axi_control_wstrb), .d(s_axi_control_wdata), .q(user_reg2)
    );

    // write channel: AW then W then B, one transaction at a time
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_state              <= WR_IDLE;
            wr_addr               <= '0;
            s_axi_control_awready <= 1'b0;
            s_axi_control_wready  <= 1'b0;
            s_axi_control_bvalid  <= 1'b0;
            s_axi_control_bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (s_axi_control_awready && s_axi_control_awvalid) begin
                        wr_state              <= WR_DATA;
                        wr_addr               <= s_axi_control_awaddr;
                        s_axi_control_awready <= 1'b0;
                        s_axi_control_wready  <= 1'b1;
                    end else s_axi_control_awready <= 1'b1;
                end
                WR_DATA: begin
                    if (wr_hs) begin
                        wr_state             <= WR_RESP;
                        s_axi_control_wready <= 1'b0;
                        s_axi_control_bvalid <= 1'b1;
                        s_axi_control_bresp  <= wr_hit ? RESP_OKAY : RESP_UNMAPPED;
                    end
                end
                WR_RESP: begin
                    if (s_axi_control_bready) begin
                        wr_state              <= WR_IDLE;
                        s_axi_control_bvalid  <= 1'b0;
                        s_axi_control_awready <= 1'b1;
                    end
                end
                default: begin
                    wr_state              <= WR_IDLE;
                    s_axi_control_awready <= 1'b0;
                    s_axi_control_wready  <= 1'b0;
                    s_axi_control_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // read channel: data is captured at the AR handshake and held until R handshake
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_state              <= RD_IDLE;
            s_axi_control_arready <= 1'b0;
            s_axi_control_rvalid  <= 1'b0;
            s_axi_control_rdata   <= '0;
            s_axi_control_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state              <= RD_DATA;
                        s_axi_control_arready <= 1'b0;
                        s_axi_control_rvalid  <= 1'b1;
                        s_axi_control_rdata   <= rd_val;
                        s_axi_control_rresp   <= rd_hit ? RESP_OKAY : RESP_UNMAPPED;
                    end else s_axi_control_arready <= 1'b1;
                end
                default: begin
                    if (s_axi_control_rready) begin
                        rd_state              <= RD_IDLE;
                        s_axi_control_rvalid  <= 1'b0;
                        s_axi_control_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // ap_start runs until done; done is sticky until CTRL is read, a new done wins over the clear
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ap_start    <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            ap_start    <= (wr_hs && wr_off == AW'(OFF_CTRL) && s_axi_control_wstrb[0] && s_axi_control_wdata[0])
                         | (ap_start & ~ap_done_i);
            done_sticky <= ap_done_i | (done_sticky & ~(ar_hs && rd_off == AW'(OFF_CTRL)));
        end
    end
endmodule

// File: tb/tb_axil_ctrl_regs.sv
// tb_axil_ctrl_regs: directed self-checking bench for the AXI4-Lite control register bank
module tb_axil_ctrl_regs;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [11:0] araddr = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        ap_start, ap_done_i = 1'b0, ap_idle_i = 1'b0;
    logic [31:0] user_reg0, user_reg1, user_reg2;
    logic [31:0] status_i = 32'hDEAD_BEEF;
    int          total = 0, passed = 0;
    logic [31:0] rd;
    logic [1:0]  rsp;
`ifdef AXIL_CTRL_REGS_SLVERR_EN
    localparam logic [1:0] EXP_UNMAP = 2'b10;
`else
    localparam logic [1:0] EXP_UNMAP = 2'b00;
`endif

    axil_ctrl_regs dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready), .s_axi_control_awaddr(awaddr),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready), .s_axi_control_wdata(wdata),
        .s_axi_control_wstrb(wstrb), .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
        .s_axi_control_bresp(bresp), .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
        .s_axi_control_araddr(araddr), .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
        .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
        .ap_start(ap_start), .ap_done_i(ap_done_i), .ap_idle_i(ap_idle_i),
        .user_reg0(user_reg0), .user_reg1(user_reg1), .user_reg2(user_reg2), .status_i(status_i)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        awaddr = a; awvalid = 1'b1; n = 0;
        while (!awready && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (!awready) begin check("aw_timeout", 32'd0, 32'd1); awvalid = 1'b0; return; end
        @(posedge ap_clk); #1; awvalid = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
        while (!wready && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (!wready) begin check("w_timeout", 32'd0, 32'd1); wvalid = 1'b0; return; end
        @(posedge ap_clk); #1; wvalid = 1'b0; n = 0;
        while (!bvalid && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (!bvalid) begin check("b_timeout", 32'd0, 32'd1); return; end
        resp = bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk); #1;
            check("b_hold", 32'({bvalid, awready, bresp}), 32'({1'b1, 1'b0, resp}));
        end
        bready = 1'b1; @(posedge ap_clk); #1; bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x; resp = 2'bxx;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin @(posedge ap_clk); #1; n++; end
        if (!arready) begin check("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; return; end
        @(posedge ap_clk); #1; arvalid = 1'b0;
        check("r_latency", 32'(rvalid), 32'd1);
        data = rdata; resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk); #1;
            check("r_hold", 32'({rvalid, arready}), 32'b10);
            check("r_hold_data", rdata, data);
        end
        rready = 1'b1; @(posedge ap_clk); #1; rready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_hs", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
        check("rst_start", 32'(ap_start), 32'd0);
        check("rst_regs", user_reg0 | user_reg1 | user_reg2, 32'd0);
        ap_rst = 1'b0;
        // basic RW registers
        axi_write(12'h010, 32'h1111_1111, 4'hF, 0, rsp); check("wr0_bresp", 32'(rsp), 32'd0);
        axi_write(12'h018, 32'h2222_2222, 4'hF, 0, rsp); check("wr1_bresp", 32'(rsp), 32'd0);
        axi_write(12'h020, 32'h3333_3333, 4'hF, 0, rsp); check("wr2_bresp", 32'(rsp), 32'd0);
        axi_read(12'h010, 0, rd, rsp); check("rd0", rd, 32'h1111_1111); check("rd0_rresp", 32'(rsp), 32'd0);
        axi_read(12'h018, 0, rd, rsp); check("rd1", rd, 32'h2222_2222); check("rd1_rresp", 32'(rsp), 32'd0);
        axi_read(12'h020, 0, rd, rsp); check("rd2", rd, 32'h3333_3333); check("rd2_rresp", 32'(rsp), 32'd0);
        check("user_reg0", user_reg0, 32'h1111_1111);
        check("user_reg1", user_reg1, 32'h2222_2222);
        check("user_reg2", user_reg2, 32'h3333_3333);
        // byte strobes
        axi_write(12'h010, 32'hAABB_CCDD, 4'b0101, 0, rsp);
        axi_read(12'h010, 0, rd, rsp); check("strb_rd", rd, 32'h11BB_11DD);
        axi_write(12'h018, 32'hFFFF_FFFF, 4'b0000, 0, rsp);
        check("strb0_bresp", 32'(rsp), 32'd0); check("strb0_reg1", user_reg1, 32'h2222_2222);
        axi_read(12'h013, 0, rd, rsp); check("addr_lsb_ignored", rd, 32'h11BB_11DD);
        // status register is read-only
        axi_write(12'h028, 32'h0, 4'hF, 0, rsp); check("ro_bresp", 32'(rsp), 32'd0);
        axi_read(12'h028, 0, rd, rsp); check("status_rd", rd, 32'hDEAD_BEEF);
        // ap_start / done handshake
        ap_idle_i = 1'b1;
        axi_write(12'h000, 32'h0000_0001, 4'h1, 0, rsp);
        check("start_set", 32'(ap_start), 32'd1);
        repeat (2) @(posedge ap_clk);
        #1; check("start_hold", 32'(ap_start), 32'd1);
        ap_done_i = 1'b1; @(posedge ap_clk); #1; ap_done_i = 1'b0;
        check("start_clr", 32'(ap_start), 32'd0);
        axi_read(12'h000, 0, rd, rsp); check("ctrl_rd1", rd, 32'h6);
        axi_read(12'h000, 0, rd, rsp); check("ctrl_rd2", rd, 32'h4);
        axi_write(12'h000, 32'h0000_0001, 4'h2, 0, rsp);
        check("start_nostrb", 32'(ap_start), 32'd0);
        // unmapped offset
        axi_read(12'h03C, 0, rd, rsp); check("unmap_rdata", rd, 32'd0); check("unmap_rresp", 32'(rsp), 32'(EXP_UNMAP));
        axi_write(12'h03C, 32'hFFFF_FFFF, 4'hF, 0, rsp); check("unmap_bresp", 32'(rsp), 32'(EXP_UNMAP));
        check("unmap_regs", user_reg0 ^ user_reg1 ^ user_reg2, 32'h11BB_11DD ^ 32'h2222_2222 ^ 32'h3333_3333);
        // backpressure on B and R
        axi_write(12'h018, 32'h5555_AAAA, 4'hF, 5, rsp); check("bp_bresp", 32'(rsp), 32'd0);
        axi_read(12'h018, 5, rd, rsp); check("bp_rd", rd, 32'h5555_AAAA);
        // reset in the middle of a write
        awaddr = 12'h020; awvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) begin @(posedge ap_clk); #1; end
        @(posedge ap_clk); #1; awvalid = 1'b0;
        check("mid_wready", 32'(wready), 32'd1);
        ap_rst = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge ap_clk); #1;
        check("mid_rst_hs", 32'({awready, wready, bvalid, arready, rvalid, ap_start}), 32'd0);
        check("mid_rst_regs", user_reg0 | user_reg1 | user_reg2, 32'd0);
        ap_rst = 1'b0; wvalid = 1'b0;
        @(posedge ap_clk); #1;
        check("post_rst_awready", 32'(awready), 32'd1);
        repeat (3) @(posedge ap_clk);
        #1; check("post_rst_bvalid", 32'({bvalid, user_reg2}), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
